// File: rtl/arb_pkg.sv
// Shared types for the four-source round-robin arbiter.
//   arb_state_t : arbiter FSM state (IDLE, BUSY)
//   NSRC        : number of requesting sources
package arb_pkg;

    typedef enum logic {IDLE, BUSY} arb_state_t;

    localparam int NSRC = 4;

endpackage

// File: rtl/rr_pick4.sv
// Combinational round-robin picker for four requesters.
// Finds the first set bit of req searching ptr, ptr+1, ... modulo 4.
// Ports:
//   req    [3:0] in  : candidate requests
//   ptr    [1:0] in  : highest-priority position
//   found        out : at least one request is set
//   idx    [1:0] out : index of the pick (valid when found)
//   onehot [3:0] out : one-hot form of the pick, 0 when nothing found
module rr_pick4
    import arb_pkg::*;
(
    input  logic [3:0] req,
    input  logic [1:0] ptr,
    output logic       found,
    output logic [1:0] idx,
    output logic [3:0] onehot
);

    logic [1:0] cand;

    always_comb begin
        found  = 1'b0;
        idx    = 2'd0;
        onehot = 4'b0000;
        cand   = 2'd0;
        // Walk from the farthest position back to ptr so the nearest
        // set bit is the last assignment and therefore wins.
        for (int k = NSRC - 1; k >= 0; k--) begin
            cand = ptr + 2'(k);
            if (req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
        if (found) begin
            onehot = 4'b0001 << idx;
        end
    end

endmodule

// File: rtl/arb4_rr.sv
// Four-requester round-robin arbiter with burst locking. Drives the
// select of a downstream 4:1 mux and the valid/ready handshake around it.
// A grant is held until the granted source flags last on a transferred
// beat, or until MAXB beats have transferred, then rotates.
// Ports:
//   clk            in  : rising-edge clock
//   rst            in  : synchronous active-high reset
//   req      [3:0] in  : per-source valid
//   last     [3:0] in  : per-source end-of-burst flag
//   dn_ready       in  : downstream accepts the current beat
//   gnt      [3:0] out : registered one-hot grant, 0 when idle
//   sel      [1:0] out : registered binary encoding of gnt (mux select)
//   out_valid      out : a beat is present at the mux output
//   up_ready [3:0] out : per-source ready, at most one bit high
module arb4_rr
    import arb_pkg::*;
#(
    parameter int MAXB = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic [3:0] last,
    input  logic       dn_ready,
    output logic [3:0] gnt,
    output logic [1:0] sel,
    output logic       out_valid,
    output logic [3:0] up_ready
);

    localparam int            CW       = (MAXB > 2) ? $clog2(MAXB) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(MAXB - 1);

    arb_state_t    state_q, state_d;
    logic [1:0]    ptr_q, ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    gnt_q, gnt_d;
    logic [1:0]    sel_q, sel_d;

    logic          busy;
    logic          beat;
    logic          rel;
    logic [3:0]    pick_req;
    logic [1:0]    pick_ptr;
    logic          pick_found;
    logic [1:0]    pick_idx;
    logic [3:0]    pick_onehot;

    assign gnt = gnt_q;
    assign sel = sel_q;

    // Handshake outputs depend only on registered grant and current inputs;
    // reset suppresses any transfer in the cycle it is asserted.
    always_comb begin
        busy      = (state_q == BUSY) && !rst;
        out_valid = busy && req[sel_q];
        up_ready  = busy ? (gnt_q & {4{dn_ready}}) : 4'b0000;
        beat      = out_valid && dn_ready;
        rel       = beat && (last[sel_q] || (cnt_q == CNT_LAST));
    end

    // The releasing source's req is necessarily high on its final beat, so
    // it is masked out of the re-pick; otherwise IDLE would be unreachable
    // and a lone source would keep the grant after finishing its burst.
    always_comb begin
        if (state_q == BUSY) begin
            pick_req = req & ~gnt_q;
            pick_ptr = sel_q + 2'd1;
        end else begin
            pick_req = req;
            pick_ptr = ptr_q;
        end
    end

    rr_pick4 u_pick (
        .req    (pick_req),
        .ptr    (pick_ptr),
        .found  (pick_found),
        .idx    (pick_idx),
        .onehot (pick_onehot)
    );

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        gnt_d   = gnt_q;
        sel_d   = sel_q;
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d = BUSY;
                    gnt_d   = pick_onehot;
                    sel_d   = pick_idx;
                    cnt_d   = '0;
                end
            end
            BUSY: begin
                if (rel) begin
                    ptr_d = sel_q + 2'd1;
                    cnt_d = '0;
                    if (pick_found) begin
                        gnt_d = pick_onehot;
                        sel_d = pick_idx;
                    end else begin
                        state_d = IDLE;
                        gnt_d   = 4'b0000;
                    end
                end else if (beat) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = 4'b0000;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= 2'd0;
            cnt_q   <= '0;
            gnt_q   <= 4'b0000;
            sel_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
        end
    end

endmodule

// File: tb/tb_arb4_rr.sv
// Testbench for arb4_rr (MAXB=4). Directed cycle-by-cycle stimulus; each
// beat the stimulus expects to transfer is queued with its source index and
// an independent monitor pops and compares on every out_valid&&dn_ready.
module tb_arb4_rr;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req = 4'b0000;
    logic [3:0] last = 4'b0000;
    logic       dn_ready = 1'b0;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       out_valid;
    logic [3:0] up_ready;

    int checks = 0;
    int failures = 0;
    logic [1:0] exp_q[$];

    always #5 clk = ~clk;

    arb4_rr #(.MAXB(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .last      (last),
        .dn_ready  (dn_ready),
        .gnt       (gnt),
        .sel       (sel),
        .out_valid (out_valid),
        .up_ready  (up_ready)
    );

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%b expected=%b", name, act, exp);
        end
    endtask

    // One clock cycle: apply inputs just after the edge, optionally queue an
    // expected beat, then return at the falling edge for sampling.
    task automatic drive(input logic r, input logic [3:0] rq, input logic [3:0] ls,
                         input logic dn, input logic push, input logic [1:0] src);
        @(posedge clk);
        #1;
        rst      = r;
        req      = rq;
        last     = ls;
        dn_ready = dn;
        if (push) exp_q.push_back(src);
        @(negedge clk);
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        logic [1:0] s;
        if (out_valid && dn_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL beat_unexpected actual_sel=%0d expected=no_beat", sel);
            end else begin
                s = exp_q.pop_front();
                check("beat_sel", {2'b00, sel}, {2'b00, s});
                check("beat_up_ready", up_ready, 4'b0001 << s);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] src;
        logic       dn_pat [6];
        dn_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

        // Reset
        drive(1'b1, 4'b0000, 4'b0000, 1'b1, 1'b0, 2'd0);
        drive(1'b1, 4'b0000, 4'b0000, 1'b1, 1'b0, 2'd0);
        check("rst_gnt", gnt, 4'b0000);
        check("rst_sel", {2'b00, sel}, 4'd0);
        check("rst_out_valid", {3'b000, out_valid}, 4'd0);
        check("rst_up_ready", up_ready, 4'b0000);

        // Single source, 3-beat burst
        drive(1'b0, 4'b0010, 4'b0000, 1'b1, 1'b0, 2'd0);
        check("t1_gnt_before_latency", gnt, 4'b0000);
        check("t1_valid_idle", {3'b000, out_valid}, 4'd0);
        drive(1'b0, 4'b0010, 4'b0000, 1'b1, 1'b1, 2'd1);
        check("t1_gnt", gnt, 4'b0010);
        check("t1_sel", {2'b00, sel}, 4'd1);
        drive(1'b0, 4'b0010, 4'b0000, 1'b1, 1'b1, 2'd1);
        drive(1'b0, 4'b0010, 4'b0010, 1'b1, 1'b1, 2'd1);
        drive(1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0, 2'd0);
        check("t1_idle_gnt", gnt, 4'b0000);
        check("t1_idle_valid", {3'b000, out_valid}, 4'd0);
        // ptr should now be 2: with req=0111 the pick is source 2
        drive(1'b0, 4'b0111, 4'b0111, 1'b1, 1'b0, 2'd0);
        drive(1'b0, 4'b0111, 4'b0111, 1'b1, 1'b1, 2'd2);
        check("t1_ptr_pick_sel", {2'b00, sel}, 4'd2);
        drive(1'b0, 4'b0001, 4'b0001, 1'b1, 1'b1, 2'd0);
        check("t1_handoff_gnt", gnt, 4'b0001);
        drive(1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0, 2'd0);
        check("t1_idle2_gnt", gnt, 4'b0000);

        // Rotation: all request, 2-beat bursts, order 0,1,2,3,0
        drive(1'b1, 4'b0000, 4'b0000, 1'b1, 1'b0, 2'd0);
        drive(1'b0, 4'b1111, 4'b0000, 1'b1, 1'b0, 2'd0);
        for (int b = 0; b < 5; b++) begin
            src = 2'(b % 4);
            drive(1'b0, 4'b1111, 4'b0000, 1'b1, 1'b1, src);
            check("rot_gnt_beat1", gnt, 4'b0001 << src);
            check("rot_valid_beat1", {3'b000, out_valid}, 4'd1);
            drive(1'b0, 4'b1111, 4'b0001 << src, 1'b1, 1'b1, src);
            check("rot_gnt_beat2", gnt, 4'b0001 << src);
        end

        // Fairness cap: source 3 never sends last, source 0 waiting
        drive(1'b1, 4'b0000, 4'b0000, 1'b1, 1'b0, 2'd0);
        drive(1'b0, 4'b1000, 4'b0000, 1'b1, 1'b0, 2'd0);
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 4'b1001, 4'b0000, 1'b1, 1'b1, 2'd3);
            check("cap_gnt", gnt, 4'b1000);
        end

        // Backpressure on source 0; cap release after 4 accepted beats
        for (int i = 0; i < 6; i++) begin
            drive(1'b0, 4'b0011, 4'b0000, dn_pat[i], dn_pat[i], 2'd0);
            check("bp_gnt", gnt, 4'b0001);
            check("bp_up_ready", up_ready, {3'b000, dn_pat[i]});
            check("bp_valid", {3'b000, out_valid}, 4'd1);
        end

        // Mid-burst drop on source 1
        drive(1'b0, 4'b0010, 4'b0000, 1'b1, 1'b1, 2'd1);
        check("drop_gnt_start", gnt, 4'b0010);
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0, 2'd0);
            check("drop_valid", {3'b000, out_valid}, 4'd0);
            check("drop_gnt_held", gnt, 4'b0010);
            check("drop_up_ready", up_ready, 4'b0010);
        end
        drive(1'b0, 4'b0010, 4'b0000, 1'b1, 1'b1, 2'd1);
        drive(1'b0, 4'b0010, 4'b0000, 1'b1, 1'b1, 2'd1);
        check("drop_count_held_gnt", gnt, 4'b0010);

        // Reset mid-burst
        drive(1'b1, 4'b1111, 4'b0000, 1'b1, 1'b0, 2'd0);
        check("rstmid_valid", {3'b000, out_valid}, 4'd0);
        check("rstmid_up_ready", up_ready, 4'b0000);
        drive(1'b0, 4'b1111, 4'b0000, 1'b1, 1'b0, 2'd0);
        check("rstmid_gnt", gnt, 4'b0000);
        check("rstmid_sel", {2'b00, sel}, 4'd0);
        drive(1'b0, 4'b1111, 4'b0001, 1'b1, 1'b1, 2'd0);
        check("post_rst_pick_gnt", gnt, 4'b0001);
        check("post_rst_pick_sel", {2'b00, sel}, 4'd0);

        drive(1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd0);
        check("queue_drained", 4'(exp_q.size()), 4'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
